tcmp_update_seq: RTL and testbench
==================================

# tcmp_update_seq

Sequencer that atomically loads a new 64-bit timer compare value into the compare register block through its 32-bit write port (addr/wdata/wr_en). Performs the glitch-free three-write sequence (low word to all-ones, high word, low word) so the timer interrupt never fires on a half-updated value. Sits between the APB slave decode and the compare block and shares that block's write port with direct APB writes.

## Interface
Parameters:
- ADDR_LO, 32'h0000_000C, compare low-word register address
- ADDR_HI, 32'h0000_0010, compare high-word register address

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  new 64-bit compare update requested
- req_ready  out  1  sequencer can accept a request
- req_data  in  64  requested compare value {hi, lo}
- apb_wr_en  in  1  direct APB write strobe
- apb_addr  in  32  direct APB write address
- apb_wdata  in  32  direct APB write data
- cmp_wr_en  out  1  write strobe to compare block
- cmp_addr  out  32  write address to compare block
- cmp_wdata  out  32  write data to compare block
- irq_mask  out  1  suppress timer interrupt while sequence in flight
- busy  out  1  sequence in flight
- done  out  1  one-cycle pulse, sequence completed
- err  out  1  one-cycle pulse, sequence aborted by conflicting APB write

## Operation
- States: IDLE, W_MAX, W_HI, W_LO.
- IDLE: req_ready=1. req_valid&&req_ready captures req_data into 64-bit staging register, next state W_MAX.
- W_MAX drives ADDR_LO/32'hFFFF_FFFF; W_HI drives ADDR_HI/staged[63:32]; W_LO drives ADDR_LO/staged[31:0]. Step advances W_MAX→W_HI→W_LO→IDLE when the write is issued.
- Port arbitration (combinational mux): apb_wr_en=1 always wins; cmp_* = apb_*. Sequencer write not issued that cycle.
- APB write during W_* to address ≠ ADDR_LO/ADDR_HI: stall, state holds, step retried next cycle.
- APB write during W_* to ADDR_LO or ADDR_HI: abort; firmware value wins. Next state IDLE, err pulses next cycle, done not pulsed, staged data discarded.
- In IDLE cmp_* = apb_* pass-through; cmp_wr_en=0, cmp_addr=0, cmp_wdata=0 when no APB write and no sequencer step.
- busy = irq_mask = (state≠IDLE).
- done pulses in the cycle after the W_LO write is issued (state back in IDLE).
- Simultaneous req handshake and APB write in IDLE: both honoured (APB write passes, request accepted).

## Timing
- Reset: state IDLE, staging=0, done=0, err=0, busy=0, irq_mask=0, req_ready=1, cmp_wr_en=0.
- Reset mid-sequence: immediately IDLE, no further writes, no done/err.
- Unstalled latency: handshake edge E0; writes issued in cycles E0+1, E0+2, E0+3; done high E0+4 to E0+5; req_ready high from E0+4.
- Each APB stall adds exactly one cycle. Next request acceptable the cycle done is high.
- req_ready combinational from state; req_data sampled only at handshake.

## Structure
- Shared timer package: ADDR_LO/ADDR_HI defaults (32'hC, 32'h10), state enum type, SEQ_MAX_WORD = 32'hFFFF_FFFF.
- Single flat module, no sub-module; compare block instantiated alongside by the timer top, driven by cmp_*.

## Test plan
- Reset, req 64'h0000_0001_0000_0100 -> cmp writes (C,FFFF_FFFF),(10,0000_0001),(C,0000_0100) on three consecutive cycles; done one cycle later; compare holds 64'h0000_0001_0000_0100.
- Same request with APB write to addr 0x4 in W_HI cycle -> APB write passes, W_HI repeated next cycle, total 4 write cycles, done at E0+5.
- APB write to 0x10 data 0xAAAA during W_HI -> err pulse, no done, compare high = 0xAAAA, low = FFFF_FFFF.
- req_valid held high with back-to-back values 64'h5, 64'h6 -> second accepted the cycle done pulses; final compare 64'h6.
- rst_n asserted during W_HI -> busy=0, irq_mask=0, no further cmp_wr_en; compare block reset to all-ones.
- req_valid and APB write to 0xC in same IDLE cycle -> APB write passes, request accepted, sequence then overwrites with staged value.

Source files
------------

// File: rtl/tcmp_update_seq_pkg.sv
// Shared timer definitions: compare register addresses, sequencer state type
// and the intermediate "park" value written to the low word during an update.
package tcmp_update_seq_pkg;

  localparam logic [31:0] TCMP_ADDR_LO = 32'h0000_000C;
  localparam logic [31:0] TCMP_ADDR_HI = 32'h0000_0010;
  localparam logic [31:0] SEQ_MAX_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_W_MAX = 2'd1,
    ST_W_HI  = 2'd2,
    ST_W_LO  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/tcmp_update_seq.sv
// Atomic 64-bit timer compare update over a 32-bit write port.
// The low word is first parked at all-ones so the compare can never match on
// a half-written value, then the high word and the real low word follow.
// Direct APB writes share the port and always take priority.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no update in flight, request port ready, APB pass-through
// ST_W_MAX | write SEQ_MAX_WORD to the low compare word
// ST_W_HI  | write staged[63:32] to the high compare word
// ST_W_LO  | write staged[31:0] to the low compare word
module tcmp_update_seq
  import tcmp_update_seq_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = TCMP_ADDR_LO,
  parameter logic [31:0] ADDR_HI = TCMP_ADDR_HI
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_data,
  input  logic        apb_wr_en,
  input  logic [31:0] apb_addr,
  input  logic [31:0] apb_wdata,
  output logic        cmp_wr_en,
  output logic [31:0] cmp_addr,
  output logic [31:0] cmp_wdata,
  output logic        irq_mask,
  output logic        busy,
  output logic        done,
  output logic        err
);

  seq_state_e  state_q,  state_d;
  logic [63:0] staged_q, staged_d;
  logic        done_q,   done_d;
  logic        err_q,    err_d;

  logic        seq_active;
  logic        seq_issue;
  logic        apb_hits_cmp;
  logic [31:0] seq_addr;
  logic [31:0] seq_wdata;

  assign seq_active   = (state_q != ST_IDLE);
  assign seq_issue    = seq_active && !apb_wr_en;
  assign apb_hits_cmp = apb_wr_en && ((apb_addr == ADDR_LO) || (apb_addr == ADDR_HI));

  // Address/data the sequencer wants to write in its current step.
  always_comb begin
    seq_addr  = '0;
    seq_wdata = '0;
    case (state_q)
      ST_W_MAX: begin
        seq_addr  = ADDR_LO;
        seq_wdata = SEQ_MAX_WORD;
      end
      ST_W_HI: begin
        seq_addr  = ADDR_HI;
        seq_wdata = staged_q[63:32];
      end
      ST_W_LO: begin
        seq_addr  = ADDR_LO;
        seq_wdata = staged_q[31:0];
      end
      default: begin
        seq_addr  = '0;
        seq_wdata = '0;
      end
    endcase
  end

  // Write port arbitration: APB wins; seq_addr/seq_wdata are zero in idle.
  always_comb begin
    cmp_wr_en = apb_wr_en || seq_issue;
    cmp_addr  = apb_wr_en ? apb_addr  : seq_addr;
    cmp_wdata = apb_wr_en ? apb_wdata : seq_wdata;
  end

  // Next-state logic: accept, step, stall on unrelated APB, abort on compare APB.
  always_comb begin
    state_d  = state_q;
    staged_d = staged_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (!seq_active) begin
      if (req_valid) begin
        staged_d = req_data;
        state_d  = ST_W_MAX;
      end
    end else if (apb_hits_cmp) begin
      // Firmware touched the compare itself; its value stands.
      state_d  = ST_IDLE;
      staged_d = '0;
      err_d    = 1'b1;
    end else if (seq_issue) begin
      case (state_q)
        ST_W_MAX: state_d = ST_W_HI;
        ST_W_HI:  state_d = ST_W_LO;
        ST_W_LO: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state, staging register and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      staged_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      staged_q <= staged_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = !seq_active;
  assign busy      = seq_active;
  assign irq_mask  = seq_active;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tcmp_update_seq.sv
// Scoreboard bench for tcmp_update_seq. The reference model treats an update
// as a list of three pending writes; each cycle it predicts the port output
// and status, and a monitor compares DUT outputs against those predictions.
module tb_tcmp_update_seq;

  localparam logic [31:0] A_LO = 32'h0000_000C;
  localparam logic [31:0] A_HI = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_data = '0;
  logic        apb_wr_en = 1'b0;
  logic [31:0] apb_addr = '0;
  logic [31:0] apb_wdata = '0;
  logic        cmp_wr_en;
  logic [31:0] cmp_addr;
  logic [31:0] cmp_wdata;
  logic        irq_mask;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  tcmp_update_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .apb_wr_en (apb_wr_en),
    .apb_addr  (apb_addr),
    .apb_wdata (apb_wdata),
    .cmp_wr_en (cmp_wr_en),
    .cmp_addr  (cmp_addr),
    .cmp_wdata (cmp_wdata),
    .irq_mask  (irq_mask),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Stand-in compare register block fed by the DUT write port.
  logic [63:0] dut_cmp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dut_cmp <= '1;
    else if (cmp_wr_en) begin
      if (cmp_addr == A_LO) dut_cmp[31:0]  <= cmp_wdata;
      if (cmp_addr == A_HI) dut_cmp[63:32] <= cmp_wdata;
    end
  end

  function automatic logic [69:0] pack(input logic wr, input logic [31:0] a,
                                       input logic [31:0] d, input logic dn,
                                       input logic er, input logic bz,
                                       input logic im, input logic rd);
    return {wr, a, d, dn, er, bz, im, rd};
  endfunction

  // Reference model state
  logic [63:0] pend[$];
  logic [69:0] exp_q[$];
  logic        done_nx = 1'b0;
  logic        err_nx  = 1'b0;
  logic [63:0] m_cmp   = '1;

  task automatic check_cmp(input string name, input logic [63:0] expv);
    n_tests++;
    if (dut_cmp !== expv) begin
      n_fail++;
      $display("FAIL %s: compare reg actual %h required %h", name, dut_cmp, expv);
    end
  endtask

  // One clock cycle of stimulus plus the model's prediction for it.
  task automatic cyc(input logic rv, input logic [63:0] rd, input logic aw,
                     input logic [31:0] aa, input logic [31:0] ad,
                     input logic rst, input logic chk);
    logic        bz, wr, dn, er;
    logic [31:0] wa, wd;
    logic [63:0] w;
    @(posedge clk);
    #1;
    if (chk) check_cmp("model_cmp", m_cmp);
    rst_n     = rst;
    req_valid = rv;
    req_data  = rd;
    apb_wr_en = aw;
    apb_addr  = aa;
    apb_wdata = ad;
    cyc_no++;
    if (!rst) begin
      pend.delete();
      done_nx = 1'b0;
      err_nx  = 1'b0;
      m_cmp   = '1;
      exp_q.push_back(pack(aw, aw ? aa : 32'h0, aw ? ad : 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      bz = (pend.size() != 0);
      dn = done_nx;
      er = err_nx;
      done_nx = 1'b0;
      err_nx  = 1'b0;
      if (aw) begin
        wr = 1'b1; wa = aa; wd = ad;
      end else if (bz) begin
        w  = pend.pop_front();
        wr = 1'b1; wa = w[63:32]; wd = w[31:0];
      end else begin
        wr = 1'b0; wa = '0; wd = '0;
      end
      if (wr && wa == A_LO) m_cmp[31:0]  = wd;
      if (wr && wa == A_HI) m_cmp[63:32] = wd;
      if (bz && aw && (aa == A_LO || aa == A_HI)) begin
        pend.delete();
        err_nx = 1'b1;
      end else if (bz && !aw && pend.size() == 0) begin
        done_nx = 1'b1;
      end
      if (!bz && rv) begin
        pend.push_back({A_LO, 32'hFFFF_FFFF});
        pend.push_back({A_HI, rd[63:32]});
        pend.push_back({A_LO, rd[31:0]});
      end
      exp_q.push_back(pack(wr, wa, wd, dn, er, bz, bz, !bz));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 64'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic req(input logic [63:0] v);
    cyc(1'b1, v, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic apb(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 64'h0, 1'b1, a, d, 1'b1, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents port and status outputs.
  initial begin
    logic [69:0] e, act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = pack(cmp_wr_en, cmp_addr, cmp_wdata, done, err, busy, irq_mask, req_ready);
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL port_cycle_%0d: wr/addr/data/done/err/busy/mask/ready actual %b/%h/%h/%b%b%b%b%b required %b/%h/%h/%b%b%b%b%b",
                   cyc_no - exp_q.size(),
                   act[69], act[68:37], act[36:5], act[4], act[3], act[2], act[1], act[0],
                   e[69], e[68:37], e[36:5], e[4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    logic        rv, aw, rs;
    logic [31:0] aa;
    int          k;

    // Reset
    cyc(1'b0, 64'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1);
    check_cmp("reset_value", 64'hFFFF_FFFF_FFFF_FFFF);

    // Plain update
    req(64'h0000_0001_0000_0100);
    idle(5);
    check_cmp("plain_update", 64'h0000_0001_0000_0100);

    // Unrelated APB write stalls W_HI by one cycle
    req(64'h0000_0001_0000_0100);
    idle(1);
    apb(32'h4, 32'h1234_5678);
    idle(5);
    check_cmp("stall_update", 64'h0000_0001_0000_0100);

    // APB write to high word aborts
    req(64'h0000_0002_0000_0200);
    idle(1);
    apb(A_HI, 32'h0000_AAAA);
    idle(4);
    check_cmp("abort_hi", 64'h0000_AAAA_FFFF_FFFF);

    // Back-to-back requests with req_valid held high
    req(64'h5);
    for (int i = 0; i < 4; i++) req(64'h6);
    idle(5);
    check_cmp("back_to_back", 64'h6);

    // Reset in W_HI
    req(64'h0000_0003_0000_0300);
    idle(1);
    cyc(1'b0, 64'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(4);
    check_cmp("reset_mid_seq", 64'hFFFF_FFFF_FFFF_FFFF);

    // Request and APB write to low word in the same idle cycle
    cyc(1'b1, 64'h0000_0007_0000_0700, 1'b1, A_LO, 32'h1111_1111, 1'b1, 1'b0);
    idle(5);
    check_cmp("req_with_apb", 64'h0000_0007_0000_0700);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 99) != 0);
      rv = ($urandom_range(0, 2) == 0);
      aw = ($urandom_range(0, 4) == 0);
      k  = $urandom_range(0, 3);
      case (k)
        0: aa = 32'h4;
        1: aa = 32'h8;
        2: aa = A_LO;
        default: aa = A_HI;
      endcase
      cyc(rv, {$urandom, $urandom}, aw, aa, $urandom, rs, (i % 20) == 19);
    end
    idle(5);
    check_cmp("random_final", m_cmp);

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: pending predictions actual %0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
